// File: rtl/saturn_bus_controller.sv
// -----------------------------------------------------------------------------
// saturn_bus_controller
//
// Drives a Saturn-style nibble bus from an external four-phase sequencer.
// After reset it issues LOAD_PC with a 5-nibble start address (LSN first),
// then PC_READ, then reads nibbles forever until HALT_AFTER nibbles have been
// read, after which it halts until the next reset.
//
// Optional feature (macro SATURN_BUS_DEBUG_CHAR_EN):
//   defined   - every read nibble is shown as an ASCII hex character on
//               o_char_to_send, with a one-clock o_debug_cycle in phase 3
//               that freezes the external phase sequencer.
//   undefined - o_char_to_send = 8'h00, o_debug_cycle = 0; reads, counting
//               and halt behave the same.
//
// Parameters
//   HALT_AFTER        number of data nibbles read before halting (1..65535)
//
// Ports
//   i_clk             single clock, rising-edge active
//   i_reset           asynchronous active-high reset
//   i_phases          one-hot bus phase (informational)
//   i_phase           encoded bus phase 0..3 (the controller acts on this)
//   i_cycle_ctr       bus cycle count (informational)
//   o_bus_clk_en      bus strobe, high for the phase-1 clock of active cycles
//   o_bus_is_data     0 = command nibble, 1 = address/data nibble
//   o_bus_nibble_out  nibble driven to the bus
//   i_bus_nibble_in   nibble returned by the ROM, sampled in phase 2
//   o_debug_cycle     freezes the phase sequencer for one clock
//   o_char_to_send    ASCII hex of the last nibble read
//   o_halt            controller finished
// -----------------------------------------------------------------------------
module saturn_bus_controller #(
  parameter int HALT_AFTER = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_phases,
  input  logic [1:0]  i_phase,
  input  logic [31:0] i_cycle_ctr,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  output logic        o_debug_cycle,
  output logic [7:0]  o_char_to_send,
  output logic        o_halt
);

  typedef enum logic [2:0] {
    LOAD_PC_CMD,
    LOAD_PC_ADDR,
    PC_READ_CMD,
    READ,
    HALTED
  } state_t;

  localparam logic [3:0]  CMD_LOAD_PC = 4'h6;
  localparam logic [3:0]  CMD_PC_READ = 4'h2;
  localparam logic [19:0] START_ADDR  = 20'h00000;
  localparam logic [2:0]  LAST_ADDR   = 3'd4;

  state_t      state_q, state_d;
  logic        running_q, running_d;   // cycle 0 has begun since reset
  logic [2:0]  addr_cnt_q, addr_cnt_d; // index of the address nibble on the bus
  logic [15:0] read_cnt_q, read_cnt_d;
  logic        is_data_q, is_data_d;
  logic [3:0]  nibble_q, nibble_d;

  logic        sample;   // clock on which the ROM nibble is captured
  logic        hold;     // phase 3 is being stretched by a debug cycle
  logic        advance;  // last clock of phase 3: end of the bus cycle

  // The sequencer holds phase 3 for one extra clock during a debug cycle; only
  // the second phase-3 clock ends the bus cycle, so state advances once.
  assign sample  = running_q && (state_q == READ) && (i_phase == 2'd2);
  assign advance = running_q && (i_phase == 2'd3) && !hold;

  // Strobe is decoded from the live phase so it lines up with phase 1 exactly;
  // running_q is cleared asynchronously, so reset kills it at once.
  assign o_bus_clk_en     = running_q && (state_q != HALTED) && (i_phase == 2'd1);
  assign o_bus_is_data    = is_data_q;
  assign o_bus_nibble_out = nibble_q;
  assign o_halt           = (state_q == HALTED);

  // NOTE: async reset clears every control register, so outputs drop the
  // moment i_reset rises rather than at the next clock edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= LOAD_PC_CMD;
      running_q  <= 1'b0;
      addr_cnt_q <= '0;
      read_cnt_q <= '0;
      is_data_q  <= 1'b0;
      nibble_q   <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      running_q  <= running_d;
      addr_cnt_q <= addr_cnt_d;
      read_cnt_q <= read_cnt_d;
      is_data_q  <= is_data_d;
      nibble_q   <= nibble_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    running_d  = running_q;
    addr_cnt_d = addr_cnt_q;
    read_cnt_d = read_cnt_q;
    is_data_d  = is_data_q;
    nibble_d   = nibble_q;

    if (!running_q) begin
      // Out of reset: start cycle 0 (LOAD_PC) on the first phase 0 seen.
      if (i_phase == 2'd0) begin
        running_d = 1'b1;
        is_data_d = 1'b0;
        nibble_d  = CMD_LOAD_PC;
      end
    end else begin
      unique case (state_q)
        LOAD_PC_CMD: begin
          if (advance) begin
            state_d    = LOAD_PC_ADDR;
            addr_cnt_d = '0;
            is_data_d  = 1'b1;
            nibble_d   = START_ADDR[3:0];
          end
        end
        LOAD_PC_ADDR: begin
          if (advance) begin
            if (addr_cnt_q == LAST_ADDR) begin
              state_d   = PC_READ_CMD;
              is_data_d = 1'b0;
              nibble_d  = CMD_PC_READ;
            end else begin
              addr_cnt_d = addr_cnt_q + 3'd1;
              nibble_d   = START_ADDR[{addr_cnt_d, 2'b00} +: 4];
            end
          end
        end
        PC_READ_CMD: begin
          if (advance) begin
            state_d   = READ;
            is_data_d = 1'b1;
            nibble_d  = 4'h0;
          end
        end
        READ: begin
          if (sample) read_cnt_d = read_cnt_q + 16'd1;
          if (advance && (read_cnt_q == 16'(HALT_AFTER))) state_d = HALTED;
        end
        HALTED: ;
        default: state_d = LOAD_PC_CMD;
      endcase
    end
  end

`ifdef SATURN_BUS_DEBUG_CHAR_EN
  logic       dbg_q;
  logic [7:0] char_q;

  function automatic logic [7:0] to_hex_ascii(input logic [3:0] n);
    // 0..9 -> '0'..'9' (0x30..), A..F -> 'A'..'F' (0x41 = 0x37 + 0xA)
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Captured on the phase-2 edge, so the debug strobe covers the first phase-3
  // clock and the character stays until the next read replaces it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dbg_q  <= 1'b0;
      char_q <= 8'h00;
    end else begin
      dbg_q <= sample;
      if (sample) char_q <= to_hex_ascii(i_bus_nibble_in);
    end
  end

  assign hold           = dbg_q;
  assign o_debug_cycle  = dbg_q;
  assign o_char_to_send = char_q;
`else
  assign hold           = 1'b0;
  assign o_debug_cycle  = 1'b0;
  assign o_char_to_send = 8'h00;
`endif

  // Informational inputs; the ROM nibble is only consumed in the debug build.
  logic unused_inputs;
  assign unused_inputs = ^{i_phases, i_cycle_ctr, i_bus_nibble_in};

endmodule

// File: tb/tb_saturn_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_saturn_bus_controller
//
// Directed bench for saturn_bus_controller with HALT_AFTER = 4. A free-running
// four-phase sequencer (frozen by o_debug_cycle) drives the phase inputs; a
// small ROM returns 3, A, F, 7 on reads 1..4. Strobed (is_data, nibble) pairs
// are logged and compared with the expected LOAD_PC / address / PC_READ / read
// sequence. Character expectations follow SATURN_BUS_DEBUG_CHAR_EN.
// -----------------------------------------------------------------------------
module tb_saturn_bus_controller;

  localparam int HALT_AFTER = 4;
  localparam int N_STROBES  = 7 + HALT_AFTER;
`ifdef SATURN_BUS_DEBUG_CHAR_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  phase = 2'd2;   // sequencer deliberately not at 0 on release
  logic [3:0]  phases;
  logic [31:0] cyc = 32'd0;
  logic        bus_clk_en, bus_is_data, debug_cycle, halt;
  logic [3:0]  nibble_out, nibble_in;
  logic [7:0]  char_to_send;

  logic [3:0]  rom [0:7];
  int          data_reads = 0;

  logic [4:0]  strobes[$];
  int          strobe_cyc[$];
  logic [7:0]  dbg_chars[$];
  int          last_dbg_cyc = 0;
  int          dbg_violations = 0;
  logic        strobe_valid = 1'b0;
  logic [4:0]  last_strobe = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External phase sequencer: stalls for one clock when the DUT asks for it.
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (!debug_cycle) phase <= phase + 2'd1;
  end

  assign phases    = 4'b0001 << phase;
  assign nibble_in = rom[(data_reads - 1) & 7];

  saturn_bus_controller #(.HALT_AFTER(HALT_AFTER)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_phases         (phases),
    .i_phase          (phase),
    .i_cycle_ctr      (cyc),
    .o_bus_clk_en     (bus_clk_en),
    .o_bus_is_data    (bus_is_data),
    .o_bus_nibble_out (nibble_out),
    .i_bus_nibble_in  (nibble_in),
    .o_debug_cycle    (debug_cycle),
    .o_char_to_send   (char_to_send),
    .o_halt           (halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_strobe(input int i);
    if (i == 0) return {1'b0, 4'h6};
    if (i == 6) return {1'b0, 4'h2};
    return {1'b1, 4'h0};
  endfunction

  // Bus monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      strobe_valid = 1'b0;
    end else begin
      if (bus_clk_en) begin
        if (strobes.size() >= 7) data_reads++;
        strobes.push_back({bus_is_data, nibble_out});
        strobe_cyc.push_back(int'(cyc));
        last_strobe  = {bus_is_data, nibble_out};
        strobe_valid = 1'b1;
      end else if (strobe_valid && phase == 2'd3 && !halt) begin
        check("bus_stable_ph3", {27'd0, bus_is_data, nibble_out}, {27'd0, last_strobe});
      end
      if (debug_cycle) begin
        if (!DBG_EN || phase != 2'd3) dbg_violations++;
        dbg_chars.push_back(char_to_send);
        last_dbg_cyc = int'(cyc);
      end
    end
  end

  task automatic clear_logs();
    strobes.delete();
    strobe_cyc.delete();
    dbg_chars.delete();
    data_reads = 0;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int budget = 400;
    while (strobes.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_timeout"}, {31'd0, budget == 0}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_clk_en"}, {31'd0, bus_clk_en}, 32'd0);
    check({tag, "_is_data"}, {31'd0, bus_is_data}, 32'd0);
    check({tag, "_nibble"}, {28'd0, nibble_out}, 32'd0);
    check({tag, "_debug"}, {31'd0, debug_cycle}, 32'd0);
    check({tag, "_char"}, {24'd0, char_to_send}, 32'd0);
    check({tag, "_halt"}, {31'd0, halt}, 32'd0);
  endtask

  initial begin
    int halt_cyc;
    int budget;
    int held;
    rom[0] = 4'h3; rom[1] = 4'hA; rom[2] = 4'hF; rom[3] = 4'h7;
    rom[4] = 4'h0; rom[5] = 4'h1; rom[6] = 4'h2; rom[7] = 4'h5;

    // ---- Reset state ----------------------------------------------------
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    clear_logs();
    rst = 1'b0;

    // ---- Free run to halt -----------------------------------------------
    budget = 600;
    while (!halt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("halt_timeout", {31'd0, budget == 0}, 32'd0);
    halt_cyc = int'(cyc);

    check("strobe_count_at_halt", strobes.size(), N_STROBES);
    for (int i = 0; i < N_STROBES && i < strobes.size(); i++)
      check($sformatf("strobe_%0d", i), {27'd0, strobes[i]}, {27'd0, exp_strobe(i)});

    // Halt rises at the end of the last read cycle's (possibly stretched) phase 3.
    if (strobe_cyc.size() > 0)
      check("halt_latency", halt_cyc - strobe_cyc[strobe_cyc.size()-1], DBG_EN ? 4 : 3);

    if (DBG_EN) begin
      check("dbg_count", dbg_chars.size(), HALT_AFTER);
      if (dbg_chars.size() >= 4) begin
        check("char_read1", {24'd0, dbg_chars[0]}, 32'h33);
        check("char_read2", {24'd0, dbg_chars[1]}, 32'h41);
        check("char_read3", {24'd0, dbg_chars[2]}, 32'h46);
        check("char_read4", {24'd0, dbg_chars[3]}, 32'h37);
      end
      check("halt_after_dbg", halt_cyc - last_dbg_cyc, 2);
    end else begin
      check("dbg_count", dbg_chars.size(), 0);
    end

    // ---- Halted: no more strobes, outputs hold ----------------------------
    repeat (20) @(negedge clk);
    check("no_strobe_after_halt", strobes.size(), N_STROBES);
    check("halt_stays", {31'd0, halt}, 32'd1);
    check("halt_debug_low", {31'd0, debug_cycle}, 32'd0);
    check("halt_char_hold", {24'd0, char_to_send}, DBG_EN ? 32'h37 : 32'h00);
    check("halt_bus_hold", {27'd0, bus_is_data, nibble_out}, 32'h10);
    check("dbg_violations", dbg_violations, 0);

    // ---- Reset during the 3rd address cycle ------------------------------
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset2");
    clear_logs();
    rst = 1'b0;
    wait_strobes(4, "addr3");
    @(negedge clk);           // phase 2 of the 3rd address cycle
    check("mid_addr_is_data", {31'd0, bus_is_data}, 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    held = strobes.size();
    repeat (8) @(negedge clk);
    check("no_strobe_in_reset", strobes.size(), held);
    check("clk_en_in_reset", {31'd0, bus_clk_en}, 32'd0);
    clear_logs();
    rst = 1'b0;
    wait_strobes(7, "restart");
    if (strobes.size() >= 7) begin
      check("restart_cmd", {27'd0, strobes[0]}, {27'd0, 5'h06});
      check("restart_addr5", {27'd0, strobes[5]}, {27'd0, 5'h10});
      check("restart_pc_read", {27'd0, strobes[6]}, {27'd0, 5'h02});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
